// File: rtl/ofm_buffer_mp.sv
// ofm_buffer_mp -- output-feature-map buffer for the conv datapath.
//
// Element-addressed storage of CAPACITY DATA_W-bit elements. Writes and reads
// move LANES elements at a time starting at any element address; lanes that
// fall past the end of the map are dropped (write) or read as zero (read) and
// raise a sticky err_oob. A valid/ready dump engine streams the whole map out
// as DUMP_WORDS words, element LANES*k+0 in the MSBs of word k.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data/wr_mask   masked multi-lane write, lane i at [i*DATA_W +: DATA_W]
//   rd_en/rd_addr            multi-lane read request
//   rd_data/rd_valid         registered read result, one cycle after rd_en
//   dump_start               start a full-map dump (ignored while busy)
//   dump_busy/dump_valid/dump_ready/dump_data/dump_last/dump_done   dump stream
//   err_oob                  sticky out-of-range access flag, cleared by rst
//
// FSM states
//   IDLE | accepting reads/writes/dump_start
//   DUMP | presenting word word_idx, advancing on valid&ready
//   DONE | one-cycle dump_done pulse, still busy
module ofm_buffer_mp #(
    parameter  int DATA_W     = 8,
    parameter  int LANES      = 4,
    parameter  int CAPACITY   = 256,
    localparam int AW         = $clog2(CAPACITY),
    localparam int DUMP_WORDS = CAPACITY / LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [LANES*DATA_W-1:0] wr_data,
    input  logic [LANES-1:0]        wr_mask,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic [LANES*DATA_W-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    dump_start,
    output logic                    dump_busy,
    output logic                    dump_valid,
    input  logic                    dump_ready,
    output logic [LANES*DATA_W-1:0] dump_data,
    output logic                    dump_last,
    output logic                    dump_done,
    output logic                    err_oob
);

    localparam int KW = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

    logic [DATA_W-1:0] mem [CAPACITY];

    state_t            state, state_nxt;
    logic [KW-1:0]     word_idx, word_idx_nxt;

    logic [AW:0]       wr_lane_addr [LANES];
    logic [AW:0]       rd_lane_addr [LANES];
    logic [LANES-1:0]  wr_ok;
    logic [LANES-1:0]  rd_ok;
    logic              wr_fire;
    logic              rd_fire;
    logic              oob_hit;

    // Lane addresses carry one extra bit so a run past the end is detected
    // rather than wrapping back to element 0.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            wr_lane_addr[i] = {1'b0, wr_addr} + (AW+1)'(i);
            rd_lane_addr[i] = {1'b0, rd_addr} + (AW+1)'(i);
            wr_ok[i]        = wr_lane_addr[i] < (AW+1)'(CAPACITY);
            rd_ok[i]        = rd_lane_addr[i] < (AW+1)'(CAPACITY);
        end
    end

    assign wr_fire = wr_en && !dump_busy && !rst;
    assign rd_fire = rd_en && !dump_busy;
    assign oob_hit = (wr_fire && |(wr_mask & ~wr_ok)) || (rd_fire && |(~rd_ok));

    // Storage is deliberately not reset so a reset does not destroy a map.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i] && wr_ok[i]) begin
                    mem[wr_lane_addr[i][AW-1:0]] <= wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read samples the array before this edge's write lands, so an
    // overlapping same-cycle write is not visible to the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err_oob  <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                for (int i = 0; i < LANES; i++) begin
                    rd_data[i*DATA_W +: DATA_W] <= rd_ok[i] ? mem[rd_lane_addr[i][AW-1:0]] : '0;
                end
            end
            if (oob_hit) begin
                err_oob <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_idx <= '0;
        end else begin
            state    <= state_nxt;
            word_idx <= word_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        word_idx_nxt = word_idx;
        dump_busy    = 1'b0;
        dump_valid   = 1'b0;
        dump_last    = 1'b0;
        dump_done    = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nxt    = DUMP;
                    word_idx_nxt = '0;
                end
            end
            DUMP: begin
                dump_busy  = 1'b1;
                dump_valid = 1'b1;
                dump_last  = (word_idx == KW'(DUMP_WORDS - 1));
                if (dump_ready) begin
                    if (dump_last) begin
                        state_nxt = DONE;
                    end else begin
                        word_idx_nxt = word_idx + 1'b1;
                    end
                end
            end
            DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Dump word is read straight from the array; writes are blocked while
    // busy, so the word is stable whenever the handshake stalls.
    always_comb begin
        dump_data = '0;
        if (state == DUMP) begin
            for (int j = 0; j < LANES; j++) begin
                dump_data[(LANES-1-j)*DATA_W +: DATA_W] =
                    mem[AW'(word_idx) * AW'(LANES) + AW'(j)];
            end
        end
    end

endmodule
